// File: rtl/receiver.sv
// ---------------------------------------------------------------------------
// receiver
//
// Receives 7-bit frames from a synchronous serial line, one bit per clock,
// with no oversampling. Frame layout: start(0), d0..d6 (LSB first),
// even-parity bit P, stop(1). Completed frames go into a single output
// holding register with a valid/ready handshake.
//
// Ports
//   clk          : clock; all state changes on the rising edge
//   rstn         : asynchronous active-low reset
//   serial_in    : serial line, idle high, synchronous to clk
//   data_ready   : consumer accepts data_out while data_valid is high
//   data_out     : received data bits d6..d0
//   data_valid   : data_out / parity_error hold a frame not yet accepted
//   parity_error : parity mismatch for the frame currently on data_out
//   frame_error  : one-cycle pulse, stop bit was sampled low
//   overrun      : one-cycle pulse, good frame dropped because the
//                  holding register was still full and not being accepted
//   busy         : high whenever the receiver is not in IDLE
// ---------------------------------------------------------------------------
module receiver (
   input  logic       clk,
   input  logic       rstn,
   input  logic       serial_in,
   input  logic       data_ready,
   output logic [6:0] data_out,
   output logic       data_valid,
   output logic       parity_error,
   output logic       frame_error,
   output logic       overrun,
   output logic       busy
);

   typedef enum logic [2:0] {
      IDLE,
      DATA,
      PARITY,
      STOP,
      WAIT_IDLE
   } state_t;

   state_t     state;
   logic [2:0] bit_cnt;
   logic [6:0] shift_data;
   logic       parity_bit;

   // Frame sequencing and the output holding register live in one block.
   // The error pulses default low every cycle so they can only last one
   // cycle per event. The handshake clear comes first so that a good frame
   // completing on the same edge as an acceptance overrides it and keeps
   // data_valid high with the new data. A frame that completes while the
   // register is full and not being accepted is dropped, leaving the held
   // data untouched. A low stop bit sends the receiver to WAIT_IDLE, where
   // it must see the line high again before it can detect a new start bit.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state        <= IDLE;
         bit_cnt      <= 3'd0;
         shift_data   <= 7'h00;
         parity_bit   <= 1'b0;
         data_out     <= 7'h00;
         data_valid   <= 1'b0;
         parity_error <= 1'b0;
         frame_error  <= 1'b0;
         overrun      <= 1'b0;
      end else begin
         frame_error <= 1'b0;
         overrun     <= 1'b0;

         if (data_valid && data_ready) begin
            data_valid <= 1'b0;
         end

         case (state)
            IDLE: begin
               if (!serial_in) begin
                  state   <= DATA;
                  bit_cnt <= 3'd0;
               end
            end

            DATA: begin
               shift_data[bit_cnt] <= serial_in;
               if (bit_cnt == 3'd6) begin
                  state <= PARITY;
               end else begin
                  bit_cnt <= bit_cnt + 3'd1;
               end
            end

            PARITY: begin
               parity_bit <= serial_in;
               state      <= STOP;
            end

            STOP: begin
               if (serial_in) begin
                  state <= IDLE;
                  if (!data_valid || data_ready) begin
                     data_out     <= shift_data;
                     parity_error <= (^shift_data) != parity_bit;
                     data_valid   <= 1'b1;
                  end else begin
                     overrun <= 1'b1;
                  end
               end else begin
                  frame_error <= 1'b1;
                  state       <= WAIT_IDLE;
               end
            end

            WAIT_IDLE: begin
               if (serial_in) begin
                  state <= IDLE;
               end
            end

            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   // busy is a pure decode of the state register, so it drops together
   // with the state during reset.
   assign busy = (state != IDLE);

endmodule
